// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: instruction ops and FSM states.
package hilo_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_e;

endpackage

// File: rtl/hilo_divider.sv
// Iterative unsigned restoring divider: one quotient bit per step, MSB first.
module hilo_divider #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN:0]   trial;

  // The quotient register doubles as the dividend shifter: dividend bits leave
  // at the top while quotient bits enter at the bottom.
  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
    if (load) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
    end else if (step) begin
      if (!trial[XLEN]) begin
        rem_d = trial[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
        quo_d = {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO unit: multi-cycle multiply, iterative signed/unsigned divide, MTHI/MTLO,
// with start/busy/done handshake and flush.
module hilo_muldiv
  import hilo_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] reg_hi,
  output logic [XLEN-1:0] reg_lo
);

  localparam int unsigned CNT_MAX = (MUL_LAT > XLEN) ? MUL_LAT : XLEN;
  localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic              sgn_mul_q, sgn_mul_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              div_load, div_step, is_sdiv;
  logic [XLEN-1:0]   div_dividend, div_divisor, div_quo, div_rem;
  logic [2*XLEN-1:0] ext_a, ext_b, product;

  // Sign-extending both operands to 2*XLEN makes one modular multiply serve both
  // MULT and MULTU.
  assign ext_a   = {{XLEN{sgn_mul_q & a_q[XLEN-1]}}, a_q};
  assign ext_b   = {{XLEN{sgn_mul_q & b_q[XLEN-1]}}, b_q};
  assign product = ext_a * ext_b;

  hilo_divider #(.XLEN(XLEN)) u_divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (div_load),
    .step      (div_step),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    sgn_mul_d    = sgn_mul_q;
    neg_quo_d    = neg_quo_q;
    neg_rem_d    = neg_rem_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    done_d       = 1'b0;
    div_load     = 1'b0;
    div_step     = 1'b0;
    is_sdiv      = (op == OP_DIV);
    div_dividend = (is_sdiv && src_a[XLEN-1]) ? -src_a : src_a;
    div_divisor  = (is_sdiv && src_b[XLEN-1]) ? -src_b : src_b;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MTHI: hi_d = src_a;
            OP_MTLO: lo_d = src_a;
            OP_MULT, OP_MULTU: begin
              a_d       = src_a;
              b_d       = src_b;
              sgn_mul_d = (op == OP_MULT);
              cnt_d     = CNT_W'(MUL_LAT - 1);
              state_d   = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              a_d       = src_a;
              b_d       = src_b;
              neg_quo_d = is_sdiv & (src_a[XLEN-1] ^ src_b[XLEN-1]);
              neg_rem_d = is_sdiv & src_a[XLEN-1];
              div_load  = 1'b1;
              cnt_d     = CNT_W'(XLEN - 1);
              state_d   = S_DIV;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          hi_d    = product[2*XLEN-1:XLEN];
          lo_d    = product[XLEN-1:0];
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          div_step = 1'b1;
          if (cnt_q == '0) state_d = S_FIX;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          // Divide by zero returns the raw dividend rather than the fixed-up remainder.
          if (b_q == '0) begin
            hi_d = a_q;
            lo_d = '1;
          end else begin
            hi_d = neg_rem_q ? -div_rem : div_rem;
            lo_d = neg_quo_q ? -div_quo : div_quo;
          end
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sgn_mul_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sgn_mul_q <= sgn_mul_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign reg_hi = hi_q;
  assign reg_lo = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv against an arithmetic reference model.
module tb_hilo_muldiv;
  import hilo_pkg::*;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned MUL_LAT = 4;
  localparam int unsigned DIV_LAT = XLEN + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            start = 1'b0;
  logic            flush = 1'b0;
  logic [2:0]      op = 3'd0;
  logic [XLEN-1:0] src_a = '0;
  logic [XLEN-1:0] src_b = '0;
  logic            busy, done;
  logic [XLEN-1:0] reg_hi, reg_lo;

  int unsigned     n_vec = 0;
  int unsigned     n_bad = 0;
  logic [XLEN-1:0] exp_hi = '0;
  logic [XLEN-1:0] exp_lo = '0;

  always #5 clk = ~clk;

  hilo_muldiv #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .reg_hi (reg_hi),
    .reg_lo (reg_lo)
  );

  function automatic int op_lat(input logic [2:0] o);
    case (o)
      3'd0, 3'd1: return int'(MUL_LAT);
      3'd2, 3'd3: return int'(DIV_LAT);
      default:    return 0;
    endcase
  endfunction

  task automatic model_apply(input logic [2:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    longint     sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin p = sa * sb; exp_hi = p[63:32]; exp_lo = p[31:0]; end
      3'd1: begin p = {32'h0, a} * {32'h0, b}; exp_hi = p[63:32]; exp_lo = p[31:0]; end
      3'd2: begin
        if (b == 0) begin exp_hi = a; exp_lo = '1; end
        else begin exp_lo = 32'(sa / sb); exp_hi = 32'(sa % sb); end
      end
      3'd3: begin
        if (b == 0) begin exp_hi = a; exp_lo = '1; end
        else begin exp_lo = a / b; exp_hi = a % b; end
      end
      3'd4: exp_hi = a;
      3'd5: exp_lo = a;
      default: ;
    endcase
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the last
  // checked cycle so a following call issues back-to-back.
  task automatic run_op(input string name, input logic [2:0] o, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input int flush_at, input int inj_at);
    int          n, last;
    bit          flushed, eb, ed;
    logic [XLEN-1:0] old_hi, old_lo, want_hi, want_lo;
    n       = op_lat(o);
    flushed = (flush_at >= 0) && (flush_at <= n);
    last    = flushed ? flush_at + 1 : n + 1;
    old_hi  = exp_hi;
    old_lo  = exp_lo;
    if (!flushed) model_apply(o, a, b);
    start = 1'b1; op = o; src_a = a; src_b = b; flush = (flush_at == 0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      eb = flushed ? (k <= flush_at) : (k <= n);
      ed = !flushed && (n > 0) && (k == n + 1);
      want_hi = (k == last) ? exp_hi : old_hi;
      want_lo = (k == last) ? exp_lo : old_lo;
      n_vec += 4;
      if (busy !== eb)
        begin n_bad++; $display("FAIL %s busy cyc%0d got %0b want %0b", name, k, busy, eb); end
      if (done !== ed)
        begin n_bad++; $display("FAIL %s done cyc%0d got %0b want %0b", name, k, done, ed); end
      if (reg_hi !== want_hi)
        begin n_bad++; $display("FAIL %s hi cyc%0d got %h want %h", name, k, reg_hi, want_hi); end
      if (reg_lo !== want_lo)
        begin n_bad++; $display("FAIL %s lo cyc%0d got %h want %h", name, k, reg_lo, want_lo); end
      if (k < last) begin
        if (k == flush_at) flush = 1'b1;
        if (k == inj_at) begin start = 1'b1; op = OP_MTLO; src_a = 32'h33; end
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
      end
    end
  endtask

  task automatic check_zero(input string name);
    n_vec += 4;
    if (busy !== 1'b0)  begin n_bad++; $display("FAIL %s busy got %b want 0", name, busy); end
    if (done !== 1'b0)  begin n_bad++; $display("FAIL %s done got %b want 0", name, done); end
    if (reg_hi !== '0)  begin n_bad++; $display("FAIL %s hi got %h want 0", name, reg_hi); end
    if (reg_lo !== '0)  begin n_bad++; $display("FAIL %s lo got %h want 0", name, reg_lo); end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1 check_zero("reset_async");
    @(negedge clk); @(negedge clk);
    check_zero("reset_held");
    rst_n = 1'b1;
    exp_hi = '0; exp_lo = '0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op("mult_neg1x2",  OP_MULT,  32'hFFFF_FFFF, 32'h2, -1, -1);
    run_op("multu_max_x2", OP_MULTU, 32'hFFFF_FFFF, 32'h2, -1, -1);
    run_op("div_m7_2",     OP_DIV,   32'hFFFF_FFF9, 32'h2, -1, -1);
    run_op("div_ovf",      OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    run_op("divu_by0",     OP_DIVU,  32'h8000_0000, 32'h0, -1, -1);
    run_op("div_neg_by0",  OP_DIV,   32'hFFFF_FF00, 32'h0, -1, -1);
    run_op("op6_ignored",  3'd6,     32'hDEAD_BEEF, 32'h1, -1, -1);
    run_op("op7_ignored",  3'd7,     32'hDEAD_BEEF, 32'h1, -1, -1);
  endtask

  task automatic test_flush();
    run_op("mthi_pre",    OP_MTHI, 32'h11, 32'h0, -1, -1);
    run_op("mtlo_pre",    OP_MTLO, 32'h22, 32'h0, -1, -1);
    run_op("divu_flush",  OP_DIVU, 32'd100, 32'd7, 10, 5);
    run_op("mthi_flush",  OP_MTHI, 32'h55, 32'h0, 0, -1);
    run_op("mult_flush_last", OP_MULT, 32'd5, 32'd6, int'(MUL_LAT), -1);
    run_op("div_flush_fix",   OP_DIV, 32'd50, 32'd3, int'(DIV_LAT), -1);
    run_op("divu_inj",    OP_DIVU, 32'd100, 32'd7, -1, 5);
  endtask

  task automatic test_async_reset();
    n_vec++;
    start = 1'b1; op = OP_MULT; src_a = 32'd7; src_b = 32'd9;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_mid busy_before got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1 check_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    exp_hi = '0; exp_lo = '0;
    @(negedge clk);
    check_zero("rst_release");
    run_op("mult_3x4", OP_MULT, 32'd3, 32'd4, -1, -1);
  endtask

  task automatic test_random();
    logic [2:0]      o;
    logic [XLEN-1:0] a, b;
    int              n, fa, ia;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       a = 32'h8000_0000;
        1:       a = 32'($urandom_range(0, 200));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      n  = op_lat(o);
      fa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, n)) : -1;
      ia = (n > 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, n - 1)) : -1;
      run_op("rand", o, a, b, fa, ia);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Parametrised HI/LO unit for the 5-stage MIPS pipeline. It replaces the single-cycle HI/LO write logic in writeback with a multi-cycle multiplier and an iterative signed/unsigned divider. It exposes a start/busy/done handshake so the hazard unit can stall consumers of HI/LO. It owns the architectural HI and LO registers and handles MTHI/MTLO directly.

## Interface
Parameters:
- XLEN, 32: operand and HI/LO width.
- MUL_LAT, 4: multiply latency in busy cycles (≥1). Product is computed combinationally and retimed through a counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- start  in  1  request; sampled only in IDLE.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are ignored.
- src_a  in  XLEN  multiplicand / dividend / MTHI-MTLO data.
- src_b  in  XLEN  multiplier / divisor.
- flush  in  1  abort in-flight operation; squash same-cycle start.
- busy  out  1  operation in flight (registered).
- done  out  1  one-cycle pulse; HI/LO already hold the result.
- reg_hi  out  XLEN  HI register.
- reg_lo  out  XLEN  LO register.

## Operation
- The FSM has four states: IDLE, MUL, DIV, FIX. Reset sets the state to IDLE, busy=0, done=0, reg_hi=0, reg_lo=0, and clears the counter and datapath registers.
- IDLE with start=1, flush=0:
  - MTHI/MTLO: HI (or LO) takes src_a at the edge. There is no busy and no done. State stays IDLE.
  - MULT/MULTU: latch the operands and the signedness. Go to MUL and load counter = MUL_LAT-1.
  - DIV/DIVU: latch |a| and |b| (raw values for DIVU), plus sign_q = a[XLEN-1]^b[XLEN-1] and sign_r = a[XLEN-1] (both 0 for DIVU). Go to DIV and load counter = XLEN-1.
- MUL: decrement the counter each cycle. When the counter reaches 0, write the 2·XLEN product: HI=upper, LO=lower. Assert done next cycle and return to IDLE.
- DIV: restoring division, one quotient bit per cycle, MSB first. When the counter reaches 0, go to FIX.
- FIX: negate the quotient if sign_q and the remainder if sign_r. Write LO=quotient, HI=remainder. Assert done next cycle and return to IDLE.
- Divide by zero (src_b=0, signed or unsigned): the full latency still elapses. The result is HI=src_a (original, unnegated) and LO=all ones.
- Signed overflow (min / -1): the result is LO=min, HI=0. This falls out of the magnitude path with no special case.
- start while busy=1 is ignored, including MTHI/MTLO. Upstream must stall.
- flush=1 in any non-IDLE state:
  - next state is IDLE and busy drops next cycle;
  - HI/LO are left unchanged and no done is produced.
- flush=1 with start in IDLE: the start is dropped, including MTHI/MTLO.
- A flush in the same cycle as the final write (counter 0 in MUL, or FIX) wins: no write, no done.
- Asynchronous reset mid-operation returns every output to its reset value immediately.

## Timing
- Cycle 0 = start accepted. busy=1 in cycles 1..N. The HI/LO write happens at the edge ending cycle N. In cycle N+1, done=1, busy=0, and reg_hi/reg_lo show the new values.
- N = MUL_LAT for MULT/MULTU and N = XLEN+1 for DIV/DIVU (XLEN iterations + FIX). For XLEN=32: N=33.
- A new start is accepted in cycle N+1, so back-to-back operations are possible. done is never asserted two cycles in a row.
- MTHI/MTLO are visible in cycle 1 and leave busy and done untouched.

## Structure
- Shared package hilo_pkg holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO;
  - FSM state encodings: S_IDLE, S_MUL, S_DIV, S_FIX.
- One sub-module, hilo_divider: iterative XLEN-bit unsigned restoring divider.
  - Ports: clk, rst_n, load, step, dividend, divisor, quotient, remainder.
  - The top level owns the FSM, the sign fix-up, the multiplier and HI/LO.

## Test plan
- MULT 0xFFFFFFFF × 0x00000002 (XLEN=32, MUL_LAT=4) -> done in cycle 5; HI=0xFFFFFFFF, LO=0xFFFFFFFE; busy high cycles 1–4.
- MULTU 0xFFFFFFFF × 0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 2 -> done in cycle 34; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x80000000 / 0 -> HI=0x80000000, LO=0xFFFFFFFF, done in cycle 34.
- Preload HI=0x11, LO=0x22 via MTHI/MTLO. Then:
  - DIVU 100/7 with flush in cycle 10 -> busy=0 in cycle 11, no done, HI=0x11, LO=0x22;
  - MTLO 0x33 issued in cycle 5 while busy -> ignored.
- Deassert rst_n during cycle 3 of MULT -> busy, done, reg_hi and reg_lo are 0 immediately. After release, MULT 3×4 completes normally: LO=12, HI=0.
